// File: rtl/trigger_buffer_controller_pkg.sv
// Shared encodings for the trigger buffer controller.
// State, edge, mode and status-bit definitions.
package trigger_buffer_controller_pkg;

   typedef enum logic [1:0] {
      IDLE            = 2'd0,
      PRE_LOADING     = 2'd1,
      WAITING_TRIGGER = 2'd2,
      POST_LOADING    = 2'd3
   } cap_state_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } stat_state_t;

   localparam logic [1:0] EDGE_RISING  = 2'd0;
   localparam logic [1:0] EDGE_FALLING = 2'd1;
   localparam logic [1:0] EDGE_EITHER  = 2'd2;

   localparam logic [1:0] MODE_NORMAL = 2'd0;
   localparam logic [1:0] MODE_AUTO   = 2'd1;

   localparam int STAT_FULL   = 0;
   localparam int STAT_TRIG   = 1;
   localparam int STAT_FORCED = 2;

endpackage

// File: rtl/trigger_buffer_controller_edge.sv
// Threshold crossing detector on one selected channel.
// History is held only while the owner keeps rst low.
module channel_edge_detector
   import trigger_buffer_controller_pkg::*;
#(
   parameter int BITS_ADC     = 8,
   parameter int NUM_CHANNELS = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_CHANNELS*BITS_ADC-1:0] input_samples,
   input  logic                             input_rdy,
   input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] trigger_source,
   input  logic [BITS_ADC-1:0]              trigger_value,
   input  logic [1:0]                       trigger_edge,
   output logic                             hit
);

   logic [BITS_ADC-1:0] cur;
   logic [BITS_ADC-1:0] prev;
   logic                prev_valid;
   logic                rise;
   logic                fall;

   // select channel; out-of-range sources fall back to channel 0
   always_comb begin
      cur = input_samples[BITS_ADC-1:0];
      for (int i = 1; i < NUM_CHANNELS; i++) begin
         if (int'(trigger_source) == i) begin
            cur = input_samples[i*BITS_ADC +: BITS_ADC];
         end
      end
   end

   // remember last sample seen while armed
   always_ff @(posedge clk) begin
      if (rst) begin
         prev       <= '0;
         prev_valid <= 1'b0;
      end else if (input_rdy) begin
         prev       <= cur;
         prev_valid <= 1'b1;
      end
   end

   assign rise = prev_valid && (prev < trigger_value)
              && (cur >= trigger_value);
   assign fall = prev_valid && (prev >= trigger_value)
              && (cur < trigger_value);

   // polarity select; code 3 behaves as rising
   always_comb begin
      hit = 1'b0;
      unique case (1'b1)
         (trigger_edge == EDGE_FALLING): hit = input_rdy & fall;
         (trigger_edge == EDGE_EITHER):  hit = input_rdy & (rise | fall);
         default:                        hit = input_rdy & rise;
      endcase
   end

endmodule

// File: rtl/trigger_buffer_controller.sv
// Capture sequencer: pre/post trigger split, trigger modes,
// buffer write gating and status frame handshake.
module trigger_buffer_controller
   import trigger_buffer_controller_pkg::*;
#(
   parameter int BITS_ADC     = 8,
   parameter int NUM_CHANNELS = 2,
   parameter int CNT_W        = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_CHANNELS*BITS_ADC-1:0] input_samples,
   input  logic                             input_rdy,
   input  logic [CNT_W-1:0]                 num_samples,
   input  logic [CNT_W-1:0]                 pre_trigger,
   input  logic [BITS_ADC-1:0]              trigger_value,
   input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] trigger_source,
   input  logic [1:0]                       trigger_edge,
   input  logic [1:0]                       trigger_mode,
   input  logic                             start,
   input  logic                             stop,
   input  logic                             force_trigger,
   input  logic                             rqst_trigger_status,
   output logic                             write_enable,
   output logic [7:0]                       trigger_status_data,
   output logic                             trigger_status_rdy,
   output logic                             trigger_status_eof,
   input  logic                             trigger_status_ack
);

   cap_state_t  state, state_n;
   stat_state_t sstate, sstate_n;

   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] nm1;
   logic [CNT_W-1:0] pre_eff;
   logic             buffer_full_o;
   logic             triggered_o;
   logic             forced_o;
   logic             edge_hit;
   logic             det_rst;
   logic             auto_to;
   logic             clr;
   logic             trig_ev;
   logic             forced_ev;
   logic             full_set;
   logic [7:0]       status_d;

   assign nm1     = num_samples - CNT_W'(1);
   assign pre_eff = (pre_trigger < nm1) ? pre_trigger : nm1;
   assign det_rst = rst | (state != WAITING_TRIGGER);
   assign auto_to = (trigger_mode == MODE_AUTO)
                 && (counter == num_samples);

   channel_edge_detector #(
      .BITS_ADC     (BITS_ADC),
      .NUM_CHANNELS (NUM_CHANNELS)
   ) u_edge (
      .clk           (clk),
      .rst           (det_rst),
      .input_samples (input_samples),
      .input_rdy     (input_rdy),
      .trigger_source(trigger_source),
      .trigger_value (trigger_value),
      .trigger_edge  (trigger_edge),
      .hit           (edge_hit)
   );

   // capture state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // capture next state and datapath strobes
   always_comb begin
      state_n   = state;
      clr       = 1'b0;
      trig_ev   = 1'b0;
      forced_ev = 1'b0;
      full_set  = 1'b0;
      if (start) begin
         clr = 1'b1;
         if (num_samples == '0) begin
            full_set = 1'b1;
            state_n  = IDLE;
         end else begin
            state_n  = PRE_LOADING;
         end
      end else if (stop) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            PRE_LOADING: begin
               if (counter == pre_eff) state_n = WAITING_TRIGGER;
            end
            WAITING_TRIGGER: begin
               if (edge_hit | force_trigger | auto_to) begin
                  trig_ev   = 1'b1;
                  forced_ev = force_trigger | (auto_to & ~edge_hit);
                  state_n   = POST_LOADING;
               end else if (counter == num_samples) begin
                  full_set  = 1'b1;
               end
            end
            POST_LOADING: begin
               if (counter == num_samples) begin
                  full_set = 1'b1;
                  state_n  = IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // sample counter and capture flags
   always_ff @(posedge clk) begin
      if (rst) begin
         counter       <= '0;
         buffer_full_o <= 1'b0;
         triggered_o   <= 1'b0;
         forced_o      <= 1'b0;
      end else if (clr) begin
         counter       <= '0;
         buffer_full_o <= full_set;
         triggered_o   <= 1'b0;
         forced_o      <= 1'b0;
      end else if (trig_ev) begin
         counter       <= pre_eff + CNT_W'(input_rdy);
         buffer_full_o <= 1'b0;
         triggered_o   <= 1'b1;
         forced_o      <= forced_ev;
      end else begin
         counter       <= counter + CNT_W'(input_rdy);
         if (full_set) buffer_full_o <= 1'b1;
      end
   end

   // buffer write gate
   always_comb begin
      write_enable = (state != IDLE);
   end

   // pack flags into the status byte
   always_comb begin
      status_d              = '0;
      status_d[STAT_FULL]   = buffer_full_o;
      status_d[STAT_TRIG]   = triggered_o;
      status_d[STAT_FORCED] = forced_o;
   end

   // status byte follows the flags one cycle late
   always_ff @(posedge clk) begin
      if (rst) trigger_status_data <= '0;
      else     trigger_status_data <= status_d;
   end

   // status handshake state register
   always_ff @(posedge clk) begin
      if (rst) sstate <= S_IDLE;
      else     sstate <= sstate_n;
   end

   // status handshake next state
   always_comb begin
      sstate_n = sstate;
      unique case (sstate)
         S_IDLE: if (rqst_trigger_status) sstate_n = S_SEND;
         S_SEND: if (trigger_status_ack)  sstate_n = S_IDLE;
         default: sstate_n = S_IDLE;
      endcase
   end

   // status handshake outputs
   always_comb begin
      trigger_status_rdy = (sstate == S_SEND);
      trigger_status_eof = (sstate == S_IDLE);
   end

endmodule

// File: tb/tb_trigger_buffer_controller.sv
// Directed and random checks of trigger_buffer_controller
// against a cycle reference model built from the capture rules.
module tb_trigger_buffer_controller;

   localparam int B  = 8;
   localparam int NC = 2;
   localparam int CW = 16;

   localparam int PH_IDLE = 0;
   localparam int PH_PRE  = 1;
   localparam int PH_WAIT = 2;
   localparam int PH_POST = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NC*B-1:0] input_samples = '0;
   logic          input_rdy = 1'b0;
   logic [CW-1:0] num_samples = '0;
   logic [CW-1:0] pre_trigger = '0;
   logic [B-1:0]  trigger_value = '0;
   logic          trigger_source = 1'b0;
   logic [1:0]    trigger_edge = '0;
   logic [1:0]    trigger_mode = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          force_trigger = 1'b0;
   logic          rqst_trigger_status = 1'b0;
   logic          trigger_status_ack = 1'b0;
   logic          write_enable;
   logic [7:0]    trigger_status_data;
   logic          trigger_status_rdy;
   logic          trigger_status_eof;

   int nvec = 0;
   int nerr = 0;

   int       m_phase = PH_IDLE;
   int       m_cnt = 0;
   bit       m_full, m_trig, m_forced, m_prev_ok, m_busy;
   logic [7:0] m_prev = '0;
   logic [7:0] m_sdata = '0;
   int       k = 0;
   bit       we_q = 1'b0;
   bit       cnt_on = 1'b0;
   int       post_w = 0;

   trigger_buffer_controller #(
      .BITS_ADC(B), .NUM_CHANNELS(NC), .CNT_W(CW)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .input_samples      (input_samples),
      .input_rdy          (input_rdy),
      .num_samples        (num_samples),
      .pre_trigger        (pre_trigger),
      .trigger_value      (trigger_value),
      .trigger_source     (trigger_source),
      .trigger_edge       (trigger_edge),
      .trigger_mode       (trigger_mode),
      .start              (start),
      .stop               (stop),
      .force_trigger      (force_trigger),
      .rqst_trigger_status(rqst_trigger_status),
      .write_enable       (write_enable),
      .trigger_status_data(trigger_status_data),
      .trigger_status_rdy (trigger_status_rdy),
      .trigger_status_eof (trigger_status_eof),
      .trigger_status_ack (trigger_status_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int eff_pre();
      int n, p;
      n = int'(num_samples);
      p = int'(pre_trigger);
      if (n == 0) return p;
      return (p < n - 1) ? p : n - 1;
   endfunction

   function automatic logic [7:0] model_cur();
      if (trigger_source == 1'b1) return input_samples[15:8];
      return input_samples[7:0];
   endfunction

   function automatic bit model_hit();
      logic [7:0] c;
      bit up, dn;
      c  = model_cur();
      up = m_prev_ok && (m_prev < trigger_value) && (c >= trigger_value);
      dn = m_prev_ok && (m_prev >= trigger_value) && (c < trigger_value);
      if (m_phase != PH_WAIT || !input_rdy) return 1'b0;
      case (trigger_edge)
         2'd1:    return dn;
         2'd2:    return up || dn;
         default: return up;
      endcase
   endfunction

   task automatic model_step();
      bit hit, auto_to;
      int pe, r;
      if (rst) begin
         m_phase = PH_IDLE; m_cnt = 0;
         m_full = 0; m_trig = 0; m_forced = 0;
         m_prev_ok = 0; m_prev = '0; m_sdata = '0; m_busy = 0;
         return;
      end
      hit = model_hit();
      pe  = eff_pre();
      r   = input_rdy ? 1 : 0;
      m_sdata = {5'b0, m_forced, m_trig, m_full};
      if (!m_busy && rqst_trigger_status) m_busy = 1;
      else if (m_busy && trigger_status_ack) m_busy = 0;
      if (m_phase == PH_WAIT) begin
         if (input_rdy) begin
            m_prev = model_cur();
            m_prev_ok = 1;
         end
      end else begin
         m_prev_ok = 0;
      end
      if (start) begin
         m_cnt = 0; m_trig = 0; m_forced = 0;
         if (num_samples == 0) begin
            m_full = 1; m_phase = PH_IDLE;
         end else begin
            m_full = 0; m_phase = PH_PRE;
         end
      end else if (stop) begin
         m_phase = PH_IDLE;
         m_cnt = (m_cnt + r) % 65536;
      end else begin
         auto_to = (trigger_mode == 2'd1) && (m_cnt == int'(num_samples));
         if (m_phase == PH_WAIT && (hit || force_trigger || auto_to)) begin
            m_cnt = pe + r;
            m_full = 0; m_trig = 1;
            m_forced = force_trigger || (auto_to && !hit);
            m_phase = PH_POST;
         end else begin
            if (m_phase == PH_PRE && m_cnt == pe) m_phase = PH_WAIT;
            else if (m_phase == PH_WAIT && m_cnt == int'(num_samples))
               m_full = 1;
            else if (m_phase == PH_POST && m_cnt == int'(num_samples)) begin
               m_full = 1; m_phase = PH_IDLE;
            end
            m_cnt = (m_cnt + r) % 65536;
         end
      end
   endtask

   task automatic check_all();
      chk("write_enable", write_enable, (m_phase != PH_IDLE));
      chk("status_data", trigger_status_data, m_sdata);
      chk("status_rdy", trigger_status_rdy, m_busy);
      chk("status_eof", trigger_status_eof, !m_busy);
      we_q = write_enable;
   endtask

   task automatic tick();
      bit rdy_now, we_now;
      int ph0;
      rdy_now = input_rdy;
      we_now  = we_q;
      ph0     = m_phase;
      @(posedge clk);
      model_step();
      if (ph0 == PH_WAIT && m_phase == PH_POST) begin
         cnt_on = 1; post_w = 0;
      end
      if (cnt_on && rdy_now && we_now
          && !(ph0 == PH_POST && m_phase == PH_IDLE)) post_w++;
      if (m_phase != PH_POST) cnt_on = 0;
      #1;
      check_all();
   endtask

   task automatic quiet();
      start = 0; stop = 0; force_trigger = 0;
      rqst_trigger_status = 0; trigger_status_ack = 0;
      input_rdy = 0; rst = 0;
   endtask

   task automatic drive(input int pat, input int pct);
      logic [7:0] v;
      input_rdy = ($urandom_range(99) < pct);
      case (pat)
         0:       v = 8'(k);
         1:       v = 8'(255 - k);
         2:       v = (((k / 3) % 2) != 0) ? 8'd150 : 8'd50;
         3:       v = 8'd42;
         default: v = 8'($urandom);
      endcase
      if (pat == 0) input_samples = {v, 8'($urandom)};
      else          input_samples = {8'($urandom), v};
      if (input_rdy) k++;
   endtask

   task automatic begin_capture();
      k = 0; post_w = 0;
      start = 1; tick(); start = 0;
   endtask

   // fpol: 0 none, 1 force on edge hit, 2 force in PRE and in WAIT
   task automatic run(input int pat, input int pct, input int fpol,
                      input int until_ph, input int maxc);
      int c, w;
      c = 0; w = 0;
      do begin
         drive(pat, pct);
         case (fpol)
            1:       force_trigger = model_hit();
            2:       force_trigger = (c == 1) || (m_phase == PH_WAIT && w == 3);
            default: force_trigger = 0;
         endcase
         if (m_phase == PH_WAIT) w++;
         tick();
         c++;
      end while (m_phase != until_ph && c < maxc);
      force_trigger = 0;
      chk("capture_end_phase", write_enable, (until_ph != PH_IDLE));
   endtask

   task automatic settle();
      quiet(); tick(); tick();
   endtask

   initial begin
      quiet(); rst = 1;
      tick(); tick();
      chk("reset_we", write_enable, 0);
      chk("reset_data", trigger_status_data, 0);
      chk("reset_eof", trigger_status_eof, 1);
      rst = 0;
      tick();

      // normal rising capture on channel 1
      num_samples = 10; pre_trigger = 4; trigger_value = 100;
      trigger_source = 1; trigger_edge = 0; trigger_mode = 0;
      begin_capture();
      chk("start_latency_we", write_enable, 1);
      run(0, 100, 0, PH_IDLE, 400);
      chk("rise_post_writes", post_w, 6);
      settle();
      chk("rise_final_data", trigger_status_data, 8'h03);

      // falling edge on channel 0, random sample gaps
      trigger_source = 0; trigger_edge = 1; pre_trigger = 6;
      begin_capture();
      run(1, 70, 0, PH_IDLE, 800);
      chk("fall_post_writes", post_w, 4);
      settle();
      chk("fall_final_data", trigger_status_data, 8'h03);

      // either edge on a square wave; crossings in PRE ignored
      trigger_edge = 2; pre_trigger = 8; num_samples = 14;
      begin_capture();
      run(2, 100, 0, PH_IDLE, 400);
      chk("either_post_writes", post_w, 6);
      settle();
      chk("either_final_data", trigger_status_data, 8'h03);

      // auto mode on flat input
      num_samples = 8; pre_trigger = 2; trigger_mode = 1;
      trigger_edge = 0;
      begin_capture();
      run(3, 100, 0, PH_IDLE, 200);
      chk("auto_post_writes", post_w, 6);
      settle();
      chk("auto_final_data", trigger_status_data, 8'h07);

      // manual force in PRE (ignored) and in WAIT
      trigger_mode = 0; num_samples = 12; pre_trigger = 5;
      begin_capture();
      run(3, 100, 2, PH_IDLE, 200);
      chk("force_post_writes", post_w, 7);
      settle();
      chk("force_final_data", trigger_status_data, 8'h07);

      // force coincident with an edge hit
      trigger_edge = 2; num_samples = 10; pre_trigger = 3;
      begin_capture();
      run(2, 100, 1, PH_IDLE, 200);
      chk("force_hit_post_writes", post_w, 7);
      settle();
      chk("force_hit_final_data", trigger_status_data, 8'h07);

      // pre_trigger beyond num_samples
      trigger_edge = 0; trigger_source = 1;
      num_samples = 10; pre_trigger = 20;
      begin_capture();
      run(0, 100, 0, PH_IDLE, 400);
      chk("clip_post_writes", post_w, 1);
      settle();

      // zero-length capture
      num_samples = 0;
      begin_capture();
      settle();
      chk("zero_we", write_enable, 0);
      chk("zero_data", trigger_status_data, 8'h01);

      // start wins over stop
      num_samples = 10; pre_trigger = 4;
      start = 1; stop = 1; tick();
      chk("start_stop_we", write_enable, 1);
      start = 0; tick();
      settle();
      chk("stop_we", write_enable, 0);

      // reset while post loading
      begin_capture();
      run(0, 100, 0, PH_POST, 400);
      rst = 1; tick(); rst = 0;
      chk("rst_post_we", write_enable, 0);
      chk("rst_post_eof", trigger_status_eof, 1);
      tick();
      chk("rst_post_data", trigger_status_data, 0);

      // status handshake with delayed ack
      rqst_trigger_status = 1; tick(); rqst_trigger_status = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hs_hold_rdy", trigger_status_rdy, 1);
         chk("hs_hold_eof", trigger_status_eof, 0);
      end
      rqst_trigger_status = 1; tick(); rqst_trigger_status = 0;
      trigger_status_ack = 1; tick(); trigger_status_ack = 0;
      chk("hs_ack_rdy", trigger_status_rdy, 0);
      chk("hs_ack_eof", trigger_status_eof, 1);
      tick();
      chk("hs_ignored_rqst", trigger_status_rdy, 0);

      // reset during a pending frame
      rqst_trigger_status = 1; tick(); rqst_trigger_status = 0;
      rst = 1; tick(); rst = 0;
      chk("rst_send_rdy", trigger_status_rdy, 0);
      chk("rst_send_eof", trigger_status_eof, 1);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         rst   = ($urandom_range(999) < 4);
         start = ($urandom_range(99) < 3);
         if (start) begin
            num_samples    = 16'($urandom_range(20));
            pre_trigger    = 16'($urandom_range(25));
            trigger_value  = 8'($urandom);
            trigger_source = 1'($urandom);
            trigger_edge   = 2'($urandom);
            trigger_mode   = 2'($urandom);
         end
         stop                = ($urandom_range(99) < 1);
         force_trigger       = ($urandom_range(99) < 2);
         rqst_trigger_status = ($urandom_range(99) < 5);
         trigger_status_ack  = ($urandom_range(99) < 30);
         drive(4, 70);
         tick();
      end
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
